// File: rtl/uart_tx_framed_if.sv
// Character handshake between upstream control logic and the framed UART transmitter.
// Writes happen on any cycle where valid and ready are both high.
interface uart_tx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_framed.sv
// Parametrised UART transmitter with a small input FIFO.
// Supports configurable baud rate, character width, parity and stop bits; queued characters go out back-to-back.
module uart_tx_framed #(
    parameter int CLK_RATE_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_framed_if.slave             bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        done,
    output logic                        UART_TX
);
    localparam int CPB = CLK_RATE_HZ / BAUD_RATE;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int IW  = 4;

    generate
        if (CPB < 2) begin : g_bad_cpb
            $error("uart_tx_framed: CYCLES_PER_BIT must be >= 2");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_framed: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_framed: PARITY must be 0..2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_framed: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
            $error("uart_tx_framed: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    state_t               state, state_d;
    logic [CW-1:0]        cyc, cyc_d;
    logic [IW-1:0]        idx, idx_d;
    logic [DATA_BITS-1:0] sh, sh_d;
    logic                 par, par_d;
    logic                 tx_d, busy_d, done_d;
    logic                 pop, push, full, bit_end;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;

    assign full      = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign bus.ready = !full && !reset;
    assign push      = bus.valid && bus.ready;
    assign bit_end   = (cyc == CW'(CPB - 1));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cyc        <= '0;
            idx        <= '0;
            sh         <= '0;
            par        <= 1'b0;
            UART_TX    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            state      <= state_d;
            cyc        <= cyc_d;
            idx        <= idx_d;
            sh         <= sh_d;
            par        <= par_d;
            UART_TX    <= tx_d;
            busy       <= busy_d;
            done       <= done_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // idx counts data bits in DATA and stop bits in STOP; sh shifts so bit 0 is always the current data bit.
    always_comb begin
        state_d = state;
        cyc_d   = cyc + 1'b1;
        idx_d   = idx;
        sh_d    = sh;
        par_d   = par;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                cyc_d = '0;
                if (fifo_count != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    idx_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_d = '0;
                    if (idx == IW'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_d = idx + 1'b1;
                        sh_d  = sh >> 1;
                    end
                end
            end
            S_PAR: begin
                if (bit_end) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cyc_d = '0;
                    if (idx == IW'(STOP_BITS - 1)) begin
                        idx_d = '0;
                        if (fifo_count != '0) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            sh_d  = mem[rd_ptr];
            par_d = (PARITY == 2) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
        end
    end

    // Outputs are registered from the next state so the line changes on the same edge as the state.
    always_comb begin
        busy_d = (state_d != S_IDLE);
        done_d = (state == S_STOP) && (state_d != S_STOP);
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = sh_d[0];
            S_PAR:   tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end
endmodule
